// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: shared command encoding, buffer index type and free-buffer selection
package fb_sched_pkg;
  typedef enum logic [1:0] {CMD_REFRESH = 2'd0, CMD_READ = 2'd1, CMD_WRITE = 2'd2} cmd_op_t;
  typedef logic [1:0] buf_idx_t;
  function automatic buf_idx_t pick_free(input buf_idx_t a, input buf_idx_t b);
    return (a != 2'd0 && b != 2'd0) ? 2'd0 : (a != 2'd1 && b != 2'd1) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/refresh_timer.sv
// refresh_timer: interval counter producing saturating refresh obligations and a sticky overrun flag
module refresh_timer #(
  parameter int INTERVAL = 750,
  parameter int MAX      = 8,
  parameter int PW       = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          take_i,
  output logic [PW-1:0] pending_o,
  output logic          overrun_o
);
  localparam int CW = $clog2(INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic ovr_q, ovr_d, wrap;
  // wrap earns an obligation, a taken refresh pays one; both together cancel
  always_comb begin
    wrap   = cnt_q == LAST;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    ovr_d  = ovr_q | (wrap & (pend_q == PMAX));
    pend_d = (wrap == take_i) ? pend_q : wrap ? ((pend_q == PMAX) ? pend_q : pend_q + 1'b1) : pend_q - 1'b1;
  end
  // timer state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pend_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end
  assign pending_o = pend_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: arbitrates refresh/read/write bursts to the SDRAM engine with triple-buffered frames
module frame_buffer_scheduler
  import fb_sched_pkg::*;
#(
  parameter int ADDR_WIDTH       = 22,
  parameter int BURST_LEN        = 8,
  parameter int FRAME_WORDS      = 153600,
  parameter int BUF_SHIFT        = 18,
  parameter int FIFO_AW          = 9,
  parameter int REFRESH_INTERVAL = 750,
  parameter int REFRESH_URGENT   = 2,
  parameter int REFRESH_MAX      = 8,
  parameter int READ_LOW_WATER   = 64,
  parameter int WRITE_HIGH_WATER = 256
) (
  input  logic                  sdram_clk_i,
  input  logic                  resetn_i,
  input  logic [FIFO_AW:0]      rd_fifo_level_i,
  input  logic [FIFO_AW:0]      wr_fifo_level_i,
  input  logic                  frame_start_i,
  input  logic                  vsync_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [1:0]            cmd_op_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  input  logic                  cmd_done_i,
  output logic                  refresh_overrun_o
);
  localparam int LW = FIFO_AW + 1;
  localparam int PW = $clog2(REFRESH_MAX + 1);
  localparam logic [LW-1:0] RD_LOW  = LW'(READ_LOW_WATER);
  localparam logic [LW-1:0] WR_HIGH = LW'(WRITE_HIGH_WATER);
  localparam logic [LW-1:0] BL_LVL  = LW'(BURST_LEN);
  localparam logic [LW-1:0] RD_ROOM = LW'(2 ** FIFO_AW - BURST_LEN);
  localparam logic [PW-1:0] URGENT  = PW'(REFRESH_URGENT);
  localparam logic [BUF_SHIFT-1:0] STEP     = BUF_SHIFT'(BURST_LEN);
  localparam logic [BUF_SHIFT-1:0] LAST_PTR = BUF_SHIFT'(FRAME_WORDS - BURST_LEN);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;
  state_t state_q, state_d;
  cmd_op_t op_q, op_d, gnt_op;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUF_SHIFT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  buf_idx_t wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, lc_q, lc_d;
  logic wr_act_q, wr_act_d, rd_act_q, rd_act_d;
  logic gnt, hs;
  logic [PW-1:0] pending;
  assign hs = (state_q == S_ISSUE) & cmd_ready_i;
  refresh_timer #(.INTERVAL(REFRESH_INTERVAL), .MAX(REFRESH_MAX), .PW(PW)) u_refresh (
    .clk_i    (sdram_clk_i),
    .rst_ni   (resetn_i),
    .take_i   (hs & (op_q == CMD_REFRESH)),
    .pending_o(pending),
    .overrun_o(refresh_overrun_o)
  );
  // priority arbitration: urgent refresh, starving reader, overfull writer, then opportunistic work
  always_comb begin
    gnt    = 1'b1;
    gnt_op = CMD_REFRESH;
    if (pending >= URGENT) gnt_op = CMD_REFRESH;
    else if (rd_act_q && rd_fifo_level_i < RD_LOW) gnt_op = CMD_READ;
    else if (wr_act_q && wr_fifo_level_i >= WR_HIGH) gnt_op = CMD_WRITE;
    else if (pending != '0) gnt_op = CMD_REFRESH;
    else if (rd_act_q && rd_fifo_level_i <= RD_ROOM) gnt_op = CMD_READ;
    else if (wr_act_q && wr_fifo_level_i >= BL_LVL) gnt_op = CMD_WRITE;
    else gnt = 1'b0;
  end
  // command FSM; op and address are latched at grant so they hold steady through the offer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    if (state_q == S_IDLE && gnt) begin
      state_d = S_ISSUE;
      op_d    = gnt_op;
      addr_d  = gnt_op == CMD_READ  ? ADDR_WIDTH'({rd_buf_q, rd_ptr_q}) :
                gnt_op == CMD_WRITE ? ADDR_WIDTH'({wr_buf_q, wr_ptr_q}) : '0;
    end else if (hs) state_d = S_BUSY;
    else if (state_q == S_BUSY && cmd_done_i) state_d = S_IDLE;
  end
  // frame bookkeeping: write completion, then vsync, then frame_start, each seeing the prior result
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_buf_d = wr_buf_q;
    rd_buf_d = rd_buf_q;
    lc_d     = lc_q;
    wr_act_d = wr_act_q;
    rd_act_d = rd_act_q;
    if (hs && op_q == CMD_WRITE) begin
      wr_ptr_d = wr_ptr_q + STEP;
      if (wr_ptr_q == LAST_PTR) begin
        wr_act_d = 1'b0;
        lc_d     = wr_buf_q;
      end
    end
    if (hs && op_q == CMD_READ) begin
      rd_ptr_d = rd_ptr_q + STEP;
      if (rd_ptr_q == LAST_PTR) rd_act_d = 1'b0;
    end
    if (vsync_i) begin
      rd_buf_d = lc_d;
      rd_ptr_d = '0;
      rd_act_d = 1'b1;
    end
    if (frame_start_i) begin
      wr_ptr_d = '0;
      wr_act_d = 1'b1;
      wr_buf_d = pick_free(rd_buf_d, lc_d);
    end
  end
  // state registers
  always_ff @(posedge sdram_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      op_q     <= CMD_REFRESH;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_buf_q <= 2'd1;
      rd_buf_q <= 2'd0;
      lc_q     <= 2'd0;
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
      lc_q     <= lc_d;
      wr_act_q <= wr_act_d;
      rd_act_q <= rd_act_d;
    end
  end
  assign cmd_valid_o = state_q == S_ISSUE;
  assign cmd_op_o    = op_q;
  assign cmd_addr_o  = addr_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb_frame_buffer_scheduler: randomized scoreboard bench against a behavioural scheduler model
module tb_frame_buffer_scheduler;
  localparam int FW = 64;
  localparam int RI = 750;
  localparam int BL = 8;
  localparam int BS = 18;
  logic clk = 1'b0, resetn = 1'b0;
  logic [9:0] rd_lvl = '0, wr_lvl = '0;
  logic fs = 1'b0, vs = 1'b0, ready = 1'b0, done = 1'b0;
  logic valid, ovr;
  logic [1:0] op;
  logic [21:0] addr;
  always #5 clk = ~clk;
  frame_buffer_scheduler #(.FRAME_WORDS(FW)) dut (
    .sdram_clk_i(clk), .resetn_i(resetn), .rd_fifo_level_i(rd_lvl), .wr_fifo_level_i(wr_lvl),
    .frame_start_i(fs), .vsync_i(vs), .cmd_valid_o(valid), .cmd_ready_i(ready),
    .cmd_op_o(op), .cmd_addr_o(addr), .cmd_done_i(done), .refresh_overrun_o(ovr)
  );
  int checks = 0, passed = 0;
  typedef struct {int op; int addr;} exp_t;
  exp_t q[$];
  // model: ph 0 idle, 1 offering, 2 awaiting done
  int ph = 0, cur_op = 0, tmr = 0, pend = 0, m_ovr = 0;
  int rbuf = 0, lc = 0, wbuf = 1, wact = 0, ract = 0, wptr = 0, rptr = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int grant_op();
    if (pend >= 2) return 0;
    if (ract != 0 && rd_lvl < 64) return 1;
    if (wact != 0 && wr_lvl >= 256) return 2;
    if (pend != 0) return 0;
    if (ract != 0 && 512 - int'(rd_lvl) >= BL) return 1;
    if (wact != 0 && int'(wr_lvl) >= BL) return 2;
    return -1;
  endfunction
  task automatic model_step();
    int g;
    bit hs, dn, wrap, take;
    if (!resetn) begin
      ph = 0; cur_op = 0; tmr = 0; pend = 0; m_ovr = 0;
      rbuf = 0; lc = 0; wbuf = 1; wact = 0; ract = 0; wptr = 0; rptr = 0;
      q.delete();
      return;
    end
    g = (ph == 0) ? grant_op() : -1;
    if (g >= 0) q.push_back('{g, g == 1 ? rbuf * 2 ** BS + rptr : g == 2 ? wbuf * 2 ** BS + wptr : 0});
    hs = ph == 1 && ready;
    dn = ph == 2 && done;
    wrap = tmr == RI - 1;
    take = hs && cur_op == 0;
    if (wrap && pend == 8) m_ovr = 1;
    if (wrap && !take) pend = pend < 8 ? pend + 1 : 8;
    else if (take && !wrap) pend--;
    tmr = wrap ? 0 : tmr + 1;
    if (hs && cur_op == 2) begin
      wptr += BL;
      if (wptr == FW) begin wact = 0; lc = wbuf; end
    end
    if (hs && cur_op == 1) begin
      rptr += BL;
      if (rptr == FW) ract = 0;
    end
    if (vs) begin rbuf = lc; rptr = 0; ract = 1; end
    if (fs) begin
      wptr = 0; wact = 1;
      for (int i = 2; i >= 0; i--) if (i != rbuf && i != lc) wbuf = i;
    end
    if (g >= 0) begin ph = 1; cur_op = g; end
    else if (hs) ph = 2;
    else if (dn) ph = 0;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  // monitor: offer timing and overrun every cycle, command contents on each handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resetn) begin
      chk("valid_timing", int'(valid), int'(ph == 1));
      chk("overrun", int'(ovr), m_ovr);
      if (valid && ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_cmd: got op=%0d addr=%0d expected no command", op, addr);
        end else begin
          e = q.pop_front();
          chk("cmd_op", int'(op), e.op);
          chk("cmd_addr", int'(addr), e.addr);
        end
      end
    end
  end
  task automatic cycle(input int ready_pct, input int pulse_div, input bit rnd_lvl);
    @(posedge clk);
    #2;
    ready = $urandom_range(99, 0) < ready_pct;
    done = (ph == 2) ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
    if (rnd_lvl) begin
      rd_lvl = 10'($urandom_range(512, 0));
      wr_lvl = 10'($urandom_range(511, 0));
    end
    fs = pulse_div != 0 && $urandom % pulse_div == 0;
    vs = pulse_div != 0 && $urandom % pulse_div == 0;
    if (pulse_div != 0 && ph == 1 && cur_op == 2 && wptr == FW - BL && $urandom % 2 == 0) begin
      ready = 1'b1; vs = 1'b1; fs = 1'b1;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_op"}, int'(op), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_overrun"}, int'(ovr), 0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(posedge clk);
    #2 resetn = 1'b1;
    repeat (2 * RI + 100) cycle(100, 0, 0);
    chk("idle_no_overrun", int'(ovr), 0);
    repeat (9 * RI + 10) cycle(0, 0, 0);
    chk("overrun_sticky", int'(ovr), 1);
    repeat (200) cycle(100, 0, 0);
    repeat (20000) cycle(80, 300, 1);
    n = 0;
    while (ph == 0 && n < 5000) begin
      cycle(80, 300, 1);
      n++;
    end
    if (ph == 0) begin
      checks++;
      $display("FAIL busy_wait: got no command within %0d cycles expected one", n);
    end
    resetn = 1'b0; ready = 1'b0; done = 1'b0; fs = 1'b0; vs = 1'b0;
    #1 chk_reset("midburst_reset");
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (RI + 50) cycle(100, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
